// File: rtl/bubble_host_pkg.sv
// Shared types and constants for the bubble host power sequencer.
package bubble_host_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRE_DELAY  = 3'd1,
    ST_WAIT_READY = 3'd2,
    ST_FILTER     = 3'd3,
    ST_RUN        = 3'd4,
    ST_POWER_DOWN = 3'd5,
    ST_FAULT      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE          = 2'd0,
    FC_READY_TIMEOUT = 2'd1,
    FC_READY_LOST    = 2'd2,
    FC_PD_TIMEOUT    = 2'd3
  } fault_code_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bubble_host_power_sequencer_if.sv
// Control/status bundle between bench control logic, the drive and the sequencer.
interface bubble_host_power_sequencer_if;
  import bubble_host_pkg::*;

  logic             start;
  logic             stop;
  logic             clear_fault;
  logic             temperature_low;
  logic             power_good;
  logic             host_ready;
  logic             fault;
  logic [1:0]       fault_code;
  logic [2:0]       state;
  logic [CNT_W-1:0] ready_latency;

  modport master (
    output start, stop, clear_fault, temperature_low,
    input  power_good, host_ready, fault, fault_code, state, ready_latency
  );

  modport slave (
    input  start, stop, clear_fault, temperature_low,
    output power_good, host_ready, fault, fault_code, state, ready_latency
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/bubble_host_power_sequencer.sv
// Host-side power-good / READY handshake sequencer with timeouts and READY supervision.
module bubble_host_power_sequencer
  import bubble_host_pkg::*;
#(
  parameter int unsigned PG_DELAY      = 16,
  parameter int unsigned READY_TIMEOUT = 8192,
  parameter int unsigned FILTER_LEN    = 4
) (
  input  logic                          master_clock,
  input  logic                          reset,
  bubble_host_power_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] PG_LAST  = CNT_W'(PG_DELAY - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FLT_LAST = CNT_W'(FILTER_LEN - 1);

  logic rdy_s;

  sync_2ff #(.WIDTH(1)) u_ready_sync (
    .clk (master_clock),
    .rst (reset),
    .d   (bus.temperature_low),
    .q   (rdy_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             frz_q, frz_d;
  fault_code_e      code_q, code_d;
  logic             pg_q, pg_d;
  logic             hr_q, hr_d;
  logic             fault_q, fault_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    lat_d   = lat_q;
    frz_d   = frz_q;
    code_d  = code_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) state_d = ST_PRE_DELAY;
      end
      ST_PRE_DELAY: begin
        if (bus.stop) begin
          state_d = ST_POWER_DOWN;
        end else if (cnt_q == PG_LAST) begin
          state_d = ST_WAIT_READY;
          lat_d   = '0;
          frz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_READY: begin
        // Latency counts until the first synced READY, then stays frozen across bounces.
        if (!frz_q) begin
          if (rdy_s) frz_d = 1'b1;
          else       lat_d = sat_inc(lat_q);
        end
        if (bus.stop) begin
          state_d = ST_POWER_DOWN;
        end else if (rdy_s) begin
          state_d = ST_FILTER;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (cnt_q >= TO_LAST) begin
          state_d = ST_FAULT;
          code_d  = FC_READY_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FILTER: begin
        if (bus.stop) begin
          state_d = ST_POWER_DOWN;
        end else if (cnt_q >= TO_LAST) begin
          state_d = ST_FAULT;
          code_d  = FC_READY_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!rdy_s)                 state_d = ST_WAIT_READY;
          else if (fcnt_q == FLT_LAST) state_d = ST_RUN;
          else                        fcnt_d  = fcnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_POWER_DOWN;
        end else if (!rdy_s) begin
          state_d = ST_FAULT;
          code_d  = FC_READY_LOST;
        end
      end
      ST_POWER_DOWN: begin
        if (!rdy_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_FAULT;
          code_d  = FC_PD_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FAULT: begin
        if (bus.clear_fault) begin
          state_d = ST_IDLE;
          code_d  = FC_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The timeout counter survives WAIT_READY <-> FILTER bounces; every other entry restarts it.
    if ((state_d != state_q) &&
        !((state_q == ST_WAIT_READY && state_d == ST_FILTER) ||
          (state_q == ST_FILTER && state_d == ST_WAIT_READY))) begin
      cnt_d = '0;
    end
    if (state_d != ST_FILTER) fcnt_d = '0;

    pg_d    = (state_d == ST_WAIT_READY) || (state_d == ST_FILTER) || (state_d == ST_RUN);
    hr_d    = (state_d == ST_RUN);
    fault_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      lat_q   <= '0;
      frz_q   <= 1'b0;
      code_q  <= FC_NONE;
      pg_q    <= 1'b0;
      hr_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      lat_q   <= lat_d;
      frz_q   <= frz_d;
      code_q  <= code_d;
      pg_q    <= pg_d;
      hr_q    <= hr_d;
      fault_q <= fault_d;
    end
  end

  assign bus.power_good    = pg_q;
  assign bus.host_ready    = hr_q;
  assign bus.fault         = fault_q;
  assign bus.fault_code    = code_q;
  assign bus.state         = state_q;
  assign bus.ready_latency = lat_q;

endmodule

// File: tb/tb_bubble_host_power_sequencer.sv
// Scoreboard bench: stimulus queues expected state transitions, a monitor pops and checks them.
module tb_bubble_host_power_sequencer;
  import bubble_host_pkg::*;

  logic master_clock = 1'b0;
  logic reset        = 1'b1;

  bubble_host_power_sequencer_if bus();

  bubble_host_power_sequencer #(
    .PG_DELAY      (16),
    .READY_TIMEOUT (8192),
    .FILTER_LEN    (4)
  ) dut (
    .master_clock (master_clock),
    .reset        (reset),
    .bus          (bus)
  );

  always #5 master_clock = ~master_clock;

  int cyc = 0;
  always @(posedge master_clock) cyc = cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  st;
    logic        pg;
    logic        hr;
    logic        flt;
    logic [1:0]  code;
    logic [15:0] lat;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  logic [2:0] prev_st = 3'd0;

  task automatic expect_at(input int c, input logic [2:0] st, input logic pg, input logic hr,
                           input logic flt, input logic [1:0] code, input logic [15:0] lat);
    exp_t e;
    e.cyc = c; e.st = st; e.pg = pg; e.hr = hr; e.flt = flt; e.code = code; e.lat = lat;
    q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge master_clock);
  endtask

  task automatic check_now(input string name, input int got, input int exp);
    tests = tests + 1;
    if (got != exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Every state change must match the next queued expectation, including the cycle it happened.
  always @(negedge master_clock) begin : monitor
    exp_t e;
    if (mon_en && (bus.state != prev_st)) begin
      tests = tests + 1;
      if (q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_transition: cycle %0d state %0d -> %0d with nothing expected",
                 cyc, prev_st, bus.state);
      end else begin
        e = q.pop_front();
        if (cyc != e.cyc || bus.state != e.st || bus.power_good != e.pg ||
            bus.host_ready != e.hr || bus.fault != e.flt || bus.fault_code != e.code ||
            bus.ready_latency != e.lat) begin
          fails = fails + 1;
          $display("FAIL transition: got cyc=%0d st=%0d pg=%0b hr=%0b flt=%0b code=%0d lat=%0d expected cyc=%0d st=%0d pg=%0b hr=%0b flt=%0b code=%0d lat=%0d",
                   cyc, bus.state, bus.power_good, bus.host_ready, bus.fault, bus.fault_code,
                   bus.ready_latency, e.cyc, e.st, e.pg, e.hr, e.flt, e.code, e.lat);
        end
      end
    end
    prev_st = bus.state;
  end

  initial begin
    int t;
    int ep;
    int r;
    bus.start = 1'b0; bus.stop = 1'b0; bus.clear_fault = 1'b0; bus.temperature_low = 1'b0;

    repeat (3) @(negedge master_clock);
    check_now("reset_state", int'(bus.state), 0);
    check_now("reset_power_good", int'(bus.power_good), 0);
    check_now("reset_host_ready", int'(bus.host_ready), 0);
    check_now("reset_fault", int'(bus.fault), 0);
    check_now("reset_fault_code", int'(bus.fault_code), 0);
    check_now("reset_latency", int'(bus.ready_latency), 0);
    mon_en = 1'b1;
    reset  = 1'b0;
    @(negedge master_clock);

    // Nominal bring-up: READY 2048 cycles after power_good
    t = cyc; bus.start = 1'b1;
    expect_at(t + 1, 3'd1, 0, 0, 0, 2'd0, 16'd0);
    ep = t + 17;
    expect_at(ep, 3'd2, 1, 0, 0, 2'd0, 16'd0);
    @(negedge master_clock); bus.start = 1'b0;
    wait_until(ep + 2048); bus.temperature_low = 1'b1;
    expect_at(ep + 2051, 3'd3, 1, 0, 0, 2'd0, 16'd2050);
    expect_at(ep + 2055, 3'd4, 1, 1, 0, 2'd0, 16'd2050);

    // READY lost in RUN
    wait_until(ep + 2060); r = cyc; bus.temperature_low = 1'b0;
    expect_at(r + 3, 3'd6, 0, 0, 1, 2'd2, 16'd2050);
    wait_until(r + 6); bus.clear_fault = 1'b1;
    expect_at(r + 7, 3'd0, 0, 0, 0, 2'd0, 16'd2050);
    @(negedge master_clock); bus.clear_fault = 1'b0;

    // READY timeout, start ignored while faulted
    t = cyc; bus.start = 1'b1;
    expect_at(t + 1, 3'd1, 0, 0, 0, 2'd0, 16'd2050);
    ep = t + 17;
    expect_at(ep, 3'd2, 1, 0, 0, 2'd0, 16'd0);
    @(negedge master_clock); bus.start = 1'b0;
    expect_at(ep + 8192, 3'd6, 0, 0, 1, 2'd1, 16'd8192);
    wait_until(ep + 8195); bus.start = 1'b1;
    wait_until(ep + 8200);
    check_now("fault_ignores_start", int'(bus.state), 6);
    check_now("fault_code_held", int'(bus.fault_code), 1);
    bus.start = 1'b0; bus.clear_fault = 1'b1;
    expect_at(cyc + 1, 3'd0, 0, 0, 0, 2'd0, 16'd8192);
    @(negedge master_clock); bus.clear_fault = 1'b0;

    // Glitchy READY then steady READY
    t = cyc; bus.start = 1'b1;
    expect_at(t + 1, 3'd1, 0, 0, 0, 2'd0, 16'd8192);
    ep = t + 17;
    expect_at(ep, 3'd2, 1, 0, 0, 2'd0, 16'd0);
    @(negedge master_clock); bus.start = 1'b0;
    wait_until(ep + 50); bus.temperature_low = 1'b1;
    wait_until(ep + 52); bus.temperature_low = 1'b0;
    expect_at(ep + 53, 3'd3, 1, 0, 0, 2'd0, 16'd52);
    expect_at(ep + 55, 3'd2, 1, 0, 0, 2'd0, 16'd52);
    wait_until(ep + 100); bus.temperature_low = 1'b1;
    expect_at(ep + 103, 3'd3, 1, 0, 0, 2'd0, 16'd52);
    expect_at(ep + 107, 3'd4, 1, 1, 0, 2'd0, 16'd52);

    // Clean power-down from RUN
    wait_until(ep + 110); bus.stop = 1'b1;
    expect_at(ep + 111, 3'd5, 0, 0, 0, 2'd0, 16'd52);
    @(negedge master_clock); bus.stop = 1'b0;
    wait_until(ep + 120); bus.temperature_low = 1'b0;
    expect_at(ep + 123, 3'd0, 0, 0, 0, 2'd0, 16'd52);
    wait_until(ep + 126);

    // Power-down with READY stuck high
    t = cyc; bus.start = 1'b1;
    expect_at(t + 1, 3'd1, 0, 0, 0, 2'd0, 16'd52);
    @(negedge master_clock); bus.start = 1'b0; bus.temperature_low = 1'b1;
    ep = t + 17;
    expect_at(ep, 3'd2, 1, 0, 0, 2'd0, 16'd0);
    expect_at(ep + 1, 3'd3, 1, 0, 0, 2'd0, 16'd0);
    expect_at(ep + 5, 3'd4, 1, 1, 0, 2'd0, 16'd0);
    wait_until(ep + 8); bus.stop = 1'b1;
    expect_at(ep + 9, 3'd5, 0, 0, 0, 2'd0, 16'd0);
    @(negedge master_clock); bus.stop = 1'b0;
    expect_at(ep + 9 + 8192, 3'd6, 0, 0, 1, 2'd3, 16'd0);
    wait_until(ep + 9 + 8195); bus.temperature_low = 1'b0; bus.clear_fault = 1'b1;
    expect_at(cyc + 1, 3'd0, 0, 0, 0, 2'd0, 16'd0);
    @(negedge master_clock); bus.clear_fault = 1'b0;

    // stop wins over start in IDLE
    bus.start = 1'b1; bus.stop = 1'b1;
    repeat (4) @(negedge master_clock);
    check_now("idle_stop_wins_state", int'(bus.state), 0);
    check_now("idle_stop_wins_pg", int'(bus.power_good), 0);
    bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge master_clock);

    // stop during PRE_DELAY
    t = cyc; bus.start = 1'b1;
    expect_at(t + 1, 3'd1, 0, 0, 0, 2'd0, 16'd0);
    @(negedge master_clock); bus.start = 1'b0;
    wait_until(t + 5); bus.stop = 1'b1;
    expect_at(t + 6, 3'd5, 0, 0, 0, 2'd0, 16'd0);
    expect_at(t + 7, 3'd0, 0, 0, 0, 2'd0, 16'd0);
    @(negedge master_clock); bus.stop = 1'b0;
    wait_until(t + 9);

    // reset in WAIT_READY
    t = cyc; bus.start = 1'b1;
    expect_at(t + 1, 3'd1, 0, 0, 0, 2'd0, 16'd0);
    ep = t + 17;
    expect_at(ep, 3'd2, 1, 0, 0, 2'd0, 16'd0);
    @(negedge master_clock); bus.start = 1'b0;
    wait_until(ep + 13); reset = 1'b1;
    expect_at(ep + 14, 3'd0, 0, 0, 0, 2'd0, 16'd0);
    @(negedge master_clock); reset = 1'b0;
    check_now("reset_mid_pg", int'(bus.power_good), 0);
    check_now("reset_mid_latency", int'(bus.ready_latency), 0);

    repeat (20) @(negedge master_clock);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL missing_transition: expected st=%0d at cycle %0d never seen", e.st, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bubble_host_power_sequencer.md
Name: bubble_host_power_sequencer

Overview:
Host-side counterpart of the drive's power-good/READY handshake, used to bench-run the cartridge without a BUBBLE SYSTEM board.
- Drives power_good into the drive.
- Waits, with a timeout, for the drive's READY (temperature_low).
- Filters READY, then reports run/fault status to bench control logic.
- Supervises READY during run and during power-down.

Parameters:
PG_DELAY, 16, cycles in PRE_DELAY before power_good asserts (>=1)
READY_TIMEOUT, 8192, max cycles in WAIT_READY/FILTER, and max cycles in POWER_DOWN (>=FILTER_LEN+1)
FILTER_LEN, 4, consecutive synced-READY-high cycles required to enter RUN (>=1)

Ports:
master_clock  in  1  48 MHz system clock; all logic on posedge
reset  in  1  synchronous, active-high
start  in  1  level; sampled in IDLE only
stop  in  1  level; requests power-down; wins over start
clear_fault  in  1  level; FAULT -> IDLE
temperature_low  in  1  READY from drive, asynchronous
power_good  out  1  to drive; registered
host_ready  out  1  high only in RUN; registered
fault  out  1  high only in FAULT; registered
fault_code  out  2  0 none, 1 READY timeout, 2 READY lost in RUN, 3 power-down timeout
state  out  3  current state encoding
ready_latency  out  16  cycles from power_good rise to first synced READY high; saturates at 16'hFFFF

Behaviour:
- Synchronization: temperature_low passes through a 2-flop synchronizer (rdy_s); FSM sees only rdy_s.
- Timing: all outputs are registered and change on the edge that enters the state.
- Reset: state=IDLE, all outputs 0, counter 0, both sync flops 0. Reset mid-operation drops power_good on the next edge.
- Single 16-bit counter cnt; it clears on every state entry unless noted.
- Encodings: IDLE=0, PRE_DELAY=1, WAIT_READY=2, FILTER=3, RUN=4, POWER_DOWN=5, FAULT=6.
- IDLE: power_good=0. start=1 and stop=0 -> PRE_DELAY.
- PRE_DELAY: counts PG_DELAY cycles, then -> WAIT_READY. power_good goes 1 on that edge; ready_latency clears to 0 on the same edge.
- WAIT_READY:
  - ready_latency increments each cycle, saturating.
  - rdy_s=1 -> FILTER; ready_latency freezes from then on.
  - cnt reaching READY_TIMEOUT-1 with rdy_s=0 -> FAULT, code 1.
- FILTER:
  - A separate filter count advances while rdy_s=1; FILTER_LEN consecutive highs -> RUN, host_ready=1.
  - rdy_s=0 -> WAIT_READY. The timeout counter is not cleared; cnt keeps running across WAIT_READY/FILTER bounces.
  - Timeout check applies here too.
- RUN: power_good=1, host_ready=1. rdy_s=0 -> FAULT, code 2.
- POWER_DOWN:
  - power_good=0.
  - rdy_s=0 -> IDLE.
  - READY_TIMEOUT cycles with rdy_s=1 -> FAULT, code 3.
  - start is ignored.
- stop: stop=1 in PRE_DELAY, WAIT_READY, FILTER or RUN -> POWER_DOWN next edge, with priority over timeout/READY events in the same cycle.
- FAULT:
  - power_good=0, host_ready=0, fault=1; fault_code held.
  - clear_fault=1 -> IDLE, fault and fault_code cleared.
  - start is ignored until cleared.
- ready_latency holds its value until the next PRE_DELAY->WAIT_READY edge.

Decomposition:
- Shared package (bubble_host_pkg): state encoding constants, fault code constants, counter width (16).
- One sub-module: sync_2ff (generic 2-flop synchronizer), reused for other async inputs in the design.

Test Plan:
- Nominal: reset, start=1; drive raises temperature_low 2048 cycles after power_good -> power_good rises 17 cycles after start sampled; ready_latency=2050 (incl. sync); host_ready after FILTER_LEN further cycles; state=4.
- Timeout: start, temperature_low held 0 -> FAULT 8192 cycles after power_good rise, fault_code=1, power_good=0; clear_fault -> state=0, fault=0.
- Glitch: READY pulses high 2 cycles then low, then steady high at cycle 100 -> FILTER->WAIT_READY->FILTER->RUN; no fault; ready_latency reflects the first glitch.
- Lost READY: in RUN drop temperature_low -> 2 cycles of sync latency later fault=1, code=2, power_good=0 on the same edge.
- Power-down: in RUN assert stop -> power_good=0 next edge; READY falls 10 cycles later -> IDLE. Repeat with READY stuck high -> FAULT code 3 after 8192 cycles.
- Priority/reset: stop and start together in IDLE -> stays IDLE. Assert reset in WAIT_READY -> all outputs 0 next edge, state=0.
